// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM states and access legality check for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP,
    ERR
  } lsu_state_e;

  // High when the access is misaligned for its size, uses a reserved funct3,
  // or is a store with an unsigned-load encoding.
  function automatic logic lsu_bad_access(input logic we, input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte/half lane extract-extend for loads and lane merge for sub-word stores
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] load_o,
  output logic [WIDTH-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the memory word and extend it to a full result.
  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    case (funct3_i)
      F3_B:    load_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   load_o = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   load_o = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Overlay the low store bytes onto the old word at the addressed lane.
  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (addr_lo_i)
          2'd0: merged_o[7:0]   = wdata_i[7:0];
          2'd1: merged_o[15:8]  = wdata_i[7:0];
          2'd2: merged_o[23:16] = wdata_i[7:0];
          2'd3: merged_o[31:24] = wdata_i[7:0];
          default: merged_o = word_i;
        endcase
      end
      F3_H: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with read-modify-write sub-word stores
module load_store_unit #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  import lsu_pkg::*;

  lsu_state_e           state_q, state_d;
  logic [IDX_BITS+1:0]  addr_q, addr_d;
  logic [2:0]           f3_q, f3_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     lane_load;
  logic [WIDTH-1:0]     lane_merged;

  // Upper address bits fall outside the memory and simply wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[WIDTH-1:IDX_BITS+2];

  lsu_lane #(.WIDTH(WIDTH)) u_lane (
    .word_i    (mem_rdata),
    .wdata_i   (wdata_q),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .load_o    (lane_load),
    .merged_o  (lane_merged)
  );

  // State and captured request; reset drops the write strobe without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Next state: classify the request on accept, then walk the memory phases.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[IDX_BITS+1:0];
          f3_d    = req_funct3;
          we_d    = req_we;
          wdata_d = req_wdata;
          data_d  = req_wdata;
          if (lsu_bad_access(req_we, req_funct3, req_addr[1:0])) state_d = ERR;
          else if (!req_we)                                     state_d = LOAD;
          else if (req_funct3 == F3_W)                          state_d = WRITE;
          else                                                  state_d = RMW_RD;
        end
      end
      LOAD: begin
        data_d  = lane_load;
        state_d = RESP;
      end
      RMW_RD: begin
        data_d  = lane_merged;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign mem_read    = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_write   = (state_q == WRITE);
  assign mem_address = {{(WIDTH-IDX_BITS){1'b0}}, addr_q[IDX_BITS+1:2]};
  assign mem_wdata   = (state_q == WRITE) ? data_q : '0;
  assign resp_valid  = (state_q == RESP) || (state_q == ERR);
  assign resp_err    = (state_q == ERR);
  assign resp_rdata  = (state_q == RESP && !we_q) ? data_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a word-array reference model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  bit          preload = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  logic [31:0] last_rdaddr;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem[mem_address[9:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'(k);
    end else if (mem_write) begin
      mem[mem_address[9:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) check("mem_rw_exclusive", {31'b0, mem_read & mem_write}, 32'b0);
  end

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = ref_size(f3);
    if (sz == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input string tag);
    int idx, sz, exp_lat, lat;
    bit exp_err, saw_rd, saw_wr;
    logic [31:0] w, exp_rd, mask, sh, wr_addr;
    idx = int'(addr[11:2]);
    sz = ref_size(f3);
    exp_err = ref_is_err(we, f3, addr);
    sh = 32'(addr[1:0]) * 32'd8;
    w = ref_mem[idx];
    exp_rd = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      exp_rd = w >> sh;
      if (sz == 1) begin
        exp_rd &= 32'hFF;
        if (f3 == 3'b000 && exp_rd >= 32'h80) exp_rd |= 32'hFFFFFF00;
      end else if (sz == 2) begin
        exp_rd &= 32'hFFFF;
        if (f3 == 3'b001 && exp_rd >= 32'h8000) exp_rd |= 32'hFFFF0000;
      end
    end else begin
      exp_lat = (sz == 4) ? 2 : 3;
      mask = (sz == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * sz)) - 32'd1) << sh);
      ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
    end

    drive_req(we, f3, addr, wd, tag);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom;
    req_wdata = $urandom;

    lat = 0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    wr_addr = 32'hX;
    last_wdata = 32'hX;
    last_rdaddr = 32'hX;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_read) begin
        saw_rd = 1'b1;
        last_rdaddr = mem_address;
      end
      if (mem_write) begin
        saw_wr = 1'b1;
        last_wdata = mem_wdata;
        wr_addr = mem_address;
      end
      if (resp_valid) break;
    end
    last_rdata = resp_rdata;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, " resp_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    check({tag, " resp_rdata"}, resp_rdata, exp_rd);
    check({tag, " read strobe"}, {31'b0, saw_rd}, {31'b0, !exp_err && (!we || sz != 4)});
    check({tag, " write strobe"}, {31'b0, saw_wr}, {31'b0, !exp_err && we});
    if (saw_rd) check({tag, " read index"}, last_rdaddr, 32'(idx));
    if (saw_wr) begin
      check({tag, " write index"}, wr_addr, 32'(idx));
      check({tag, " write word"}, last_wdata, ref_mem[idx]);
    end
  endtask

  initial begin
    int sent, got, cyc, last_cyc, notready;
    logic [31:0] addrs [4];
    logic [2:0]  f3_tab [8];
    logic [2:0]  f3;
    logic [31:0] ra;

    for (int k = 0; k < 1024; k++) ref_mem[k] = 32'(k);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset resp_err", {31'b0, resp_err}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_read", {31'b0, mem_read}, 32'd0);
    check("reset mem_write", {31'b0, mem_write}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;

    txn(1'b0, 3'b010, 32'h0000000C, 32'h0, "t1 LW 0xC");
    check("t1 read index const", last_rdaddr, 32'd3);
    check("t1 rdata const", last_rdata, 32'h00000003);

    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    addrs[2] = 32'h8;
    addrs[3] = 32'h1C;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = addrs[0];
    sent = 0;
    got = 0;
    cyc = 0;
    last_cyc = 0;
    notready = 0;
    while (got < 4 && cyc < 40) begin
      if (!req_ready) notready++;
      if (resp_valid) begin
        check("b2b rdata", resp_rdata, ref_mem[addrs[got][11:2]]);
        check("b2b err", {31'b0, resp_err}, 32'd0);
        if (got > 0) check("b2b spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        got++;
      end
      if (req_ready && sent < 4) begin
        @(posedge clk);
        #1;
        sent++;
        if (sent < 4) req_addr = addrs[sent];
        else req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("b2b responses", 32'(got), 32'd4);
    check("b2b busy cycles", 32'(notready), 32'd8);

    txn(1'b1, 3'b000, 32'h5, 32'h000000AB, "t2 SB 0x5");
    check("t2 SB merged const", last_wdata, 32'h0000AB01);
    txn(1'b0, 3'b100, 32'h5, 32'h0, "t2 LBU 0x5");
    check("t2 LBU const", last_rdata, 32'h000000AB);
    txn(1'b0, 3'b000, 32'h5, 32'h0, "t2 LB 0x5");
    check("t2 LB const", last_rdata, 32'hFFFFFFAB);

    txn(1'b1, 3'b001, 32'h1A, 32'h00001234, "t3 SH 0x1A");
    check("t3 SH merged const", last_wdata, 32'h12340006);
    txn(1'b0, 3'b101, 32'h1A, 32'h0, "t3 LHU 0x1A");
    check("t3 LHU const", last_rdata, 32'h00001234);
    txn(1'b0, 3'b010, 32'h18, 32'h0, "t3 LW 0x18");
    check("t3 LW const", last_rdata, 32'h12340006);

    txn(1'b0, 3'b001, 32'h3, 32'h0, "t4 LH misaligned");
    txn(1'b1, 3'b010, 32'h6, 32'h5555AAAA, "t4 SW misaligned");
    txn(1'b0, 3'b011, 32'h0, 32'h0, "t4 funct3 011");
    txn(1'b1, 3'b100, 32'h8, 32'h0, "t4 store funct3 100");

    drive_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "t5 SW abort");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t5 in WRITE", {31'b0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 mem_write async drop", {31'b0, mem_write}, 32'd0);
    check("t5 no resp during reset", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("t5 resp_valid held low", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 idle after release", {31'b0, req_ready}, 32'd1);
    check("t5 no resp after release", {31'b0, resp_valid}, 32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, "t5 LW after abort");
    check("t5 LW const", last_rdata, 32'h00000004);

    txn(1'b0, 3'b010, 32'h0001000C, 32'h0, "wrap LW");
    check("wrap LW const", last_rdata, 32'h00000003);

    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int n = 0; n < 60; n++) begin
      f3 = f3_tab[$urandom_range(0, 7)];
      ra = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      txn(1'($urandom_range(0, 1)), f3, ra, $urandom, "rand");
    end

    @(negedge clk);
    for (int k = 0; k < 16; k++) check("final memory", mem[k], ref_mem[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator for the word-wide data memory in the pipelined RISC-V core.
- Accepts one load or store per transaction from the EX/MEM pipeline register.
- Drives the memory's read/write strobes, word index and write data, and returns the sign- or zero-extended load result.
- Sub-word stores are done as a read-modify-write. Stalls the pipeline while busy.

Parameters:
- WIDTH, 32, data and byte-address width.
- IDX_BITS, 10, memory word-index width; the memory depth is 2^IDX_BITS words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present from the EX/MEM register.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data, taken from the low bits.
- resp_valid  out  1  one-cycle pulse when the transaction completes.
- resp_rdata  out  WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned access or unsupported funct3.
- mem_read  out  1  to the memory's Memread input.
- mem_write  out  1  to the memory's Memwrite input.
- mem_address  out  WIDTH  word index = {0, addr[IDX_BITS+1:2]}.
- mem_wdata  out  WIDTH  full word to write.
- mem_rdata  in  WIDTH  combinational read data from the memory.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_wdata all 0.
  - mem_write must drop immediately, because the memory is level-sensitive.
- All memory-side outputs are decoded from registered state and registers only.
- mem_read and mem_write are never high together.
- On accept, capture addr, funct3, we and wdata into registers; later changes to req_* are ignored.
- States:
  - IDLE -> ERR: misaligned access (half with addr[0]=1; word with addr[1:0]!=0), or funct3 in {011, 110, 111}, or store funct3 in {100, 101}.
  - IDLE -> LOAD: load.
  - IDLE -> WRITE: SW.
  - IDLE -> RMW_RD: SB or SH.
  - LOAD: mem_read=1. Select the byte lane (addr[1:0]) or half lane (addr[1]), extend it, and register it into resp_rdata. Go to RESP.
  - RMW_RD: mem_read=1. Register the merged word: the old word with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to WRITE.
  - WRITE: mem_write=1, mem_wdata = merged word (or wdata for SW). Go to RESP.
  - RESP: resp_valid=1, resp_err=0. Go to IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory strobe. Go to IDLE.
- Latency, with the accept edge as T:
  - Load: resp_valid in cycle T+2.
  - SW: resp_valid in cycle T+2.
  - SB/SH: resp_valid in cycle T+3.
  - Error: resp_valid in cycle T+1.
- Back-to-back: req_ready is high again in the cycle after RESP/ERR, so the sustained rate is one transaction per 3, 3, 4 or 2 cycles respectively.
- Address bits above IDX_BITS+1 are ignored, so addresses wrap modulo the memory size; no error is raised.
- Extension rules:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
- Reset asserted mid-transaction aborts it:
  - No resp_valid is produced for the aborted request.
  - An RMW aborted in RMW_RD leaves memory unmodified.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding IDLE, LOAD, RMW_RD, WRITE, RESP, ERR.
  - A function for the misalign/illegal check.
- One combinational sub-module, lsu_lane, holds the lane extract/extend and lane merge logic, shared by LOAD and RMW_RD.

Test Plan (memory preloaded with mem[k]=k for k=0..7):
1. LW at addr 0x0000000C -> mem_read high in T+1 with mem_address=3; resp_valid in T+2 with resp_rdata=0x00000003, resp_err=0.
2. SB at 0x5 with wdata 0x000000AB -> RMW_RD reads mem[1]; WRITE drives mem_wdata=0x0000AB01; then LBU at 0x5 returns 0x000000AB, and LB at 0x5 returns 0xFFFFFFAB.
3. SH at 0x1A with wdata 0x1234 (mem[6]=6) -> mem_wdata=0x12340006; LHU at 0x1A returns 0x00001234; LW at 0x18 returns 0x12340006.
4. LH at 0x3, SW at 0x6, and funct3=011 -> each gives resp_valid with resp_err=1 in T+1; mem_read and mem_write stay 0 throughout.
5. rst_n pulled low during the WRITE cycle of an SW -> mem_write falls without waiting for clk, no resp_valid, state is IDLE after release; a following LW returns a value consistent with the abort point.
6. req_valid held high with 4 queued LWs at 0x0, 0x4, 0x8, 0x1C -> responses 0, 1, 2, 7 arrive every 3 cycles; req_ready is low in the busy cycles.
